aes_cipher_arb: RTL and testbench

Two-channel request arbiter and sequencer for a single shared AES-128 encryption core (`aes_cipher_top`). It accepts encryption jobs (key + plaintext) from two independent requesters over valid/ready handshakes and grants them round-robin. For each granted job it issues the one-cycle load pulse to the core and waits for the core's done pulse, with a watchdog. It then returns the ciphertext, tagged with the requester ID, on a single buffered response port.

---
 rtl/aes_cipher_arb.sv | 166 ++++++++++++++++
 tb/tb_aes_cipher_arb.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_arb.sv
// aes_cipher_arb: two-channel round-robin arbiter and sequencer for a shared
// AES-128 core. Accepts key/plaintext jobs, pulses the core load, waits for
// core done (with watchdog), and returns ciphertext tagged with the requester.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   req_valid_i/ready_o   per-channel request handshake (ready is combinational)
//   req_key_i/text_i      {ch1, ch0} key and plaintext, 128 bits each
//   rsp_valid_o/ready_i   response handshake
//   rsp_id_o/err_o/text_o requester id, watchdog abort flag, ciphertext
//   busy_o                high whenever not idle
//   core_*                load/key/plaintext to the core, done/ciphertext back
module aes_cipher_arb #(
    parameter int unsigned TIMEOUT = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [1:0]   req_valid_i,
    output logic [1:0]   req_ready_o,
    input  logic [255:0] req_key_i,
    input  logic [255:0] req_text_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic         rsp_id_o,
    output logic         rsp_err_o,
    output logic [127:0] rsp_text_o,
    output logic         busy_o,
    output logic         core_ld_o,
    output logic [127:0] core_key_o,
    output logic [127:0] core_text_in_o,
    input  logic         core_done_i,
    input  logic [127:0] core_text_out_i
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_BUSY = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [BLK_W-1:0] key_q, key_d;
    logic [BLK_W-1:0] text_q, text_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [BLK_W-1:0] rsp_text_q, rsp_text_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_valid_q;
    logic             busy_q;
    logic             ld_q, ld_d;
    logic             gnt;
    logic             accept;

    // Round-robin pick: a lone requester wins, contention goes opposite last grant.
    always_comb begin
        gnt = 1'b0;
        case (req_valid_i)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_q;
            default: gnt = 1'b0;
        endcase
    end

    // Ready only in IDLE on the granted channel; held low while reset is asserted.
    always_comb begin
        req_ready_o = 2'b00;
        if (rst_ni && (state_q == S_IDLE) && req_valid_i[gnt]) begin
            req_ready_o[gnt] = 1'b1;
        end
    end

    assign accept = |(req_valid_i & req_ready_o);

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        text_d     = text_q;
        id_d       = id_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        rsp_text_d = rsp_text_q;
        rsp_err_d  = rsp_err_q;
        ld_d       = 1'b0;
        cnt_inc    = cnt_q + CNT_W'(1);
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    key_d   = gnt ? req_key_i[2*BLK_W-1:BLK_W]  : req_key_i[BLK_W-1:0];
                    text_d  = gnt ? req_text_i[2*BLK_W-1:BLK_W] : req_text_i[BLK_W-1:0];
                    id_d    = gnt;
                    last_d  = gnt;
                    ld_d    = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                // Timeout compares the post-increment count, so the first BUSY cycle counts as 1.
                cnt_d = cnt_inc;
                if (core_done_i) begin
                    rsp_text_d = core_text_out_i;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (cnt_inc == CNT_LAST) begin
                    rsp_text_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            text_q      <= '0;
            id_q        <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            rsp_text_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ld_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            text_q      <= text_d;
            id_q        <= id_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rsp_text_q  <= rsp_text_d;
            rsp_err_q   <= rsp_err_d;
            rsp_valid_q <= (state_d == S_RESP);
            busy_q      <= (state_d != S_IDLE);
            ld_q        <= ld_d;
        end
    end

    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_id_o       = id_q;
    assign rsp_err_o      = rsp_err_q;
    assign rsp_text_o     = rsp_text_q;
    assign busy_o         = busy_q;
    assign core_ld_o      = ld_q;
    assign core_key_o     = key_q;
    assign core_text_in_o = text_q;

endmodule

// File: tb/tb_aes_cipher_arb.sv
// Testbench for aes_cipher_arb: scoreboard of expected responses, a monitor
// that checks every DUT response and core load, and a 12-cycle core model
// that returns known AES-128 vectors.
module tb_aes_cipher_arb;

    typedef struct {
        logic [127:0] key;
        logic [127:0] pt;
    } job_t;

    typedef struct {
        logic         id;
        logic         err;
        logic [127:0] text;
        logic [127:0] key;
        logic [127:0] pt;
        int           lat;
    } exp_t;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C0  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] P1  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C1  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2  = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C2  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P3  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C3  = 128'hf5d3d58503b9699de785895a96fdbaaf;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [255:0] req_key;
    logic [255:0] req_text;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic         rsp_err;
    logic [127:0] rsp_text;
    logic         busy;
    logic         core_ld;
    logic [127:0] core_key;
    logic [127:0] core_text_in;
    logic         core_done;
    logic [127:0] core_text_out;

    logic         v0 = 1'b0, v1 = 1'b0;
    logic [127:0] k0 = '0, k1 = '0, t0 = '0, t1 = '0;
    logic         stray = 1'b0;
    logic         no_done = 1'b0;
    logic         mdone;
    logic [127:0] mout;
    logic [127:0] ckey, cpt;
    int           cd;

    job_t q0[$];
    job_t q1[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    assign req_valid     = {v1, v0};
    assign req_key       = {k1, k0};
    assign req_text      = {t1, t0};
    assign core_done     = mdone | stray;
    assign core_text_out = mout;

    aes_cipher_arb #(.TIMEOUT(32)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_key_i       (req_key),
        .req_text_i      (req_text),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_id_o        (rsp_id),
        .rsp_err_o       (rsp_err),
        .rsp_text_o      (rsp_text),
        .busy_o          (busy),
        .core_ld_o       (core_ld),
        .core_key_o      (core_key),
        .core_text_in_o  (core_text_in),
        .core_done_i     (core_done),
        .core_text_out_i (core_text_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] aes_lookup(input logic [127:0] k, input logic [127:0] p);
        if (k == K0 && p == P0) return C0;
        if (k == K1 && p == P1) return C1;
        if (k == K1 && p == P2) return C2;
        if (k == K1 && p == P3) return C3;
        return k ^ p;
    endfunction

    // Core model: done pulse in the 12th cycle after the load cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cd    <= 0;
            mdone <= 1'b0;
            mout  <= '0;
            ckey  <= '0;
            cpt   <= '0;
        end else begin
            mdone <= 1'b0;
            if (core_ld) begin
                cd   <= 11;
                ckey <= core_key;
                cpt  <= core_text_in;
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1 && !no_done) begin
                    mdone <= 1'b1;
                    mout  <= aes_lookup(ckey, cpt);
                end
            end
        end
    end

    // Requester drivers: hold a job until accepted, then present the next.
    initial begin
        logic take;
        job_t j;
        take = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (take) begin v0 = 1'b0; take = 1'b0; end
            if (!v0 && q0.size() != 0) begin
                j = q0.pop_front(); k0 = j.key; t0 = j.pt; v0 = 1'b1;
            end
            @(negedge clk);
            if (v0 && req_ready[0]) take = 1'b1;
        end
    end

    initial begin
        logic take;
        job_t j;
        take = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (take) begin v1 = 1'b0; take = 1'b0; end
            if (!v1 && q1.size() != 0) begin
                j = q1.pop_front(); k1 = j.key; t1 = j.pt; v1 = 1'b1;
            end
            @(negedge clk);
            if (v1 && req_ready[1]) take = 1'b1;
        end
    end

    // Monitor: compares DUT activity against the scoreboard head.
    logic         prev_valid = 1'b0;
    logic         prev_hs = 1'b0;
    logic         prev_id = 1'b0;
    logic         prev_err = 1'b0;
    logic [127:0] prev_text = '0;
    exp_t         e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (req_ready != 2'b00) check("ready_onehot", 128'($countones(req_ready)), 128'(1));
            if ((req_valid & req_ready) != 2'b00) acc_cyc = cyc + 1;
            if (core_ld) begin
                if (sb.size() == 0) begin
                    check("ld_unexpected", 128'(core_ld), 128'(0));
                end else begin
                    check("ld_cycle", 128'(cyc), 128'(acc_cyc));
                    check("core_key", core_key, sb[0].key);
                    check("core_text_in", core_text_in, sb[0].pt);
                end
            end
            if (prev_hs) begin
                check("idle_busy", 128'(busy), 128'(0));
                check("idle_rsp_valid", 128'(rsp_valid), 128'(0));
            end
            if (rsp_valid && !prev_valid) begin
                if (sb.size() == 0) check("rsp_unexpected", 128'(rsp_valid), 128'(0));
                else check("rsp_latency", 128'(cyc - acc_cyc), 128'(sb[0].lat));
            end
            if (rsp_valid && prev_valid && !prev_hs) begin
                check("hold_text", rsp_text, prev_text);
                check("hold_id", 128'(rsp_id), 128'(prev_id));
                check("hold_err", 128'(rsp_err), 128'(prev_err));
                check("hold_req_ready", 128'(req_ready), 128'(0));
            end
            if (rsp_valid && rsp_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("rsp_id", 128'(rsp_id), 128'(e.id));
                check("rsp_err", 128'(rsp_err), 128'(e.err));
                check("rsp_text", rsp_text, e.text);
            end
            prev_hs    = rsp_valid && rsp_ready;
            prev_valid = rsp_valid;
            prev_id    = rsp_id;
            prev_err   = rsp_err;
            prev_text  = rsp_text;
        end
    end

    task automatic expect_job(input logic ch, input logic err, input logic [127:0] key,
                              input logic [127:0] pt, input logic [127:0] ct, input int lat);
        exp_t x;
        job_t j;
        x.id = ch; x.err = err; x.text = ct; x.key = key; x.pt = pt; x.lat = lat;
        sb.push_back(x);
        j.key = key; j.pt = pt;
        if (ch) q1.push_back(j);
        else q0.push_back(j);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check({name, "_timeout"}, 128'(sb.size()), 128'(0));
            sb.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_req_ready"}, 128'(req_ready), 128'(0));
        check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        check({tag, "_rsp_id"}, 128'(rsp_id), 128'(0));
        check({tag, "_rsp_err"}, 128'(rsp_err), 128'(0));
        check({tag, "_rsp_text"}, rsp_text, 128'(0));
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_core_ld"}, 128'(core_ld), 128'(0));
        check({tag, "_core_key"}, core_key, 128'(0));
        check({tag, "_core_text_in"}, core_text_in, 128'(0));
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        #12;
        check_zero("reset");
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Single ch0 job, FIPS-197 vector.
        expect_job(1'b0, 1'b0, K0, P0, C0, 13);
        wait_drain("single", 60);

        // Watchdog on ch1: core never answers.
        no_done = 1'b1;
        expect_job(1'b1, 1'b1, K1, P1, 128'(0), 32);
        wait_drain("watchdog", 80);
        no_done = 1'b0;

        // Contention: last grant was ch1, so order is 0,1,0,1.
        expect_job(1'b0, 1'b0, K0, P0, C0, 13);
        expect_job(1'b1, 1'b0, K1, P1, C1, 13);
        expect_job(1'b0, 1'b0, K1, P2, C2, 13);
        expect_job(1'b1, 1'b0, K1, P3, C3, 13);
        wait_drain("contention", 200);

        // Response backpressure for 20 cycles.
        rsp_ready = 1'b0;
        expect_job(1'b1, 1'b0, K1, P3, C3, 13);
        n = 0;
        while (!rsp_valid && n < 60) begin @(posedge clk); n++; end
        check("bp_rsp_seen", 128'(rsp_valid), 128'(1));
        repeat (20) @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_drain("backpressure", 20);

        // Stray done in IDLE, then in LOAD.
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        @(negedge clk);
        check("stray_idle_busy", 128'(busy), 128'(0));
        check("stray_idle_rsp", 128'(rsp_valid), 128'(0));
        expect_job(1'b0, 1'b0, K1, P2, C2, 13);
        n = 0;
        while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        wait_drain("stray_load", 60);

        // Reset mid-job: job dropped, last grant returns to 1.
        expect_job(1'b0, 1'b0, K1, P1, C1, 13);
        n = 0;
        while (!core_ld && n < 20) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        check("rst_busy_before", 128'(busy), 128'(1));
        #2 rst_n = 1'b0;
        #1;
        check_zero("midjob");
        sb.delete();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        expect_job(1'b0, 1'b0, K0, P0, C0, 13);
        expect_job(1'b1, 1'b0, K1, P2, C2, 13);
        wait_drain("after_reset", 120);
        repeat (20) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
